// File: rtl/mem_tx_arbiter.sv
// Purpose : arbitrates NUM_CH requesters onto one memory TX channel and steers RX strobes back to the read's issuer via a tag FIFO.
// Latency : TX mux and grant are combinational (0 cycles); a queued tag reaches the FIFO head the cycle after it is pushed.
// Backpr. : reply-wanted commands are held off (tx_command_valid=0) while the tag FIFO is full; non-reply commands always pass.
//
// Ports:
//   clk, reset                 clock, async active-low reset
//   ch_cmd_valid/ch_reserve    per-channel request / grant-hold without a command
//   ch_reply_wanted            command expects an RX reply (queues a tag on start)
//   ch_cmd, ch_data            flattened per-channel command and payload
//   tx_command_valid/_command/tx_data  muxed request toward the memory interface
//   tx_* / rx_* inputs         memory interface strobes
//   grant                      one-hot current TX owner
//   ch_tx_*, ch_rx_*           strobes fanned back to the TX owner / oldest outstanding reader
//   full, empty, rx_orphan     tag FIFO status and sticky reply-without-request flag
module mem_tx_arbiter #(
    parameter int NUM_CH          = 2,
    parameter int IO_BITS         = 2,
    parameter int CMD_BITS        = 3,
    parameter int MAX_OUTSTANDING = 3,
    parameter int ARB_MODE        = 0,
    parameter int DEFAULT_CH      = 0,
    parameter int PAYLOAD_CYCLES  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            ch_cmd_valid,
    input  logic [NUM_CH-1:0]            ch_reserve,
    input  logic [NUM_CH-1:0]            ch_reply_wanted,
    input  logic [NUM_CH*CMD_BITS-1:0]   ch_cmd,
    input  logic [NUM_CH*IO_BITS-1:0]    ch_data,
    output logic                         tx_command_valid,
    output logic [CMD_BITS-1:0]          tx_command,
    output logic [IO_BITS-1:0]           tx_data,
    input  logic                         tx_command_started,
    input  logic                         tx_active,
    input  logic                         tx_data_next,
    input  logic                         tx_done,
    input  logic                         rx_started,
    input  logic                         rx_active,
    input  logic                         rx_sbs_valid,
    input  logic                         rx_data_valid,
    input  logic                         rx_done,
    output logic [NUM_CH-1:0]            grant,
    output logic [NUM_CH-1:0]            ch_tx_started,
    output logic [NUM_CH-1:0]            ch_tx_active,
    output logic [NUM_CH-1:0]            ch_tx_data_next,
    output logic [NUM_CH-1:0]            ch_tx_done,
    output logic [NUM_CH-1:0]            ch_rx_started,
    output logic [NUM_CH-1:0]            ch_rx_active,
    output logic [NUM_CH-1:0]            ch_rx_sbs_valid,
    output logic [NUM_CH-1:0]            ch_rx_data_valid,
    output logic [NUM_CH-1:0]            ch_rx_done,
    output logic                         full,
    output logic                         empty,
    output logic                         rx_orphan
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    // Illegal parameter sets elaborate this empty scope; it exists only so a
    // netlist viewer shows the mis-configuration by name.
    if (NUM_CH < 2 || MAX_OUTSTANDING < 1 || PAYLOAD_CYCLES < 1) begin : g_bad_params
    end

    logic [NUM_CH-1:0] want;
    logic [CH_W-1:0]   arb_idx;
    logic [CH_W-1:0]   gnt_idx;
    logic [CH_W:0]     rr_sum;
    logic [CH_W-1:0]   grant_idx_q, grant_idx_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [CH_W-1:0]   tag_mem_q [MAX_OUTSTANDING];
    logic [CH_W-1:0]   tag_mem_d [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rx_orphan_q, rx_orphan_d;
    logic              fifo_push, fifo_pop;
    logic [CH_W-1:0]   head_idx;
    logic [NUM_CH-1:0] head_oh;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Arbitration over the requesters that either have a command or hold a reservation.
    always_comb begin
        want    = ch_cmd_valid | ch_reserve;
        arb_idx = CH_W'(DEFAULT_CH);
        rr_sum  = '0;
        if (ARB_MODE == 0) begin
            // Ascending scan: the last (highest) requester seen wins.
            for (int i = 0; i < NUM_CH; i++) begin
                if (want[i]) arb_idx = CH_W'(i);
            end
        end else begin
            // Descending offset scan from the pointer: the smallest offset wins.
            for (int off = NUM_CH - 1; off >= 0; off--) begin
                rr_sum = {1'b0, rr_ptr_q} + (CH_W+1)'(off);
                if (rr_sum >= (CH_W+1)'(NUM_CH)) rr_sum = rr_sum - (CH_W+1)'(NUM_CH);
                if (want[rr_sum[CH_W-1:0]]) arb_idx = rr_sum[CH_W-1:0];
            end
        end
    end

    // Ownership is frozen for the whole transfer; otherwise it tracks the arbiter live.
    always_comb begin
        gnt_idx     = tx_active ? grant_idx_q : arb_idx;
        grant_idx_d = gnt_idx;
        rr_ptr_d    = rr_ptr_q;
        if (ARB_MODE != 0 && tx_done) begin
            rr_ptr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
        grant          = '0;
        grant[gnt_idx] = 1'b1;
    end

    assign tx_command = ch_cmd[gnt_idx*CMD_BITS +: CMD_BITS];
    assign tx_data    = ch_data[gnt_idx*IO_BITS +: IO_BITS];
    // full is taken from the registered count, so a reply leaving this cycle
    // does not open the door for a new read until next cycle.
    assign tx_command_valid = ch_cmd_valid[gnt_idx] & ~(full & ch_reply_wanted[gnt_idx]);

    assign ch_tx_started   = {NUM_CH{tx_command_started}} & grant;
    assign ch_tx_active    = {NUM_CH{tx_active}}          & grant;
    assign ch_tx_data_next = {NUM_CH{tx_data_next}}       & grant;
    assign ch_tx_done      = {NUM_CH{tx_done}}            & grant;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign rx_orphan = rx_orphan_q;
    assign head_idx  = tag_mem_q[rd_ptr_q];

    // Tag FIFO: circular buffer. At full with a simultaneous pop, the write slot
    // equals the slot being read out, so the new tag lands behind the survivors.
    always_comb begin
        tag_mem_d   = tag_mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        fifo_pop    = rx_done & ~empty;
        fifo_push   = tx_command_started & ch_reply_wanted[gnt_idx] & (~full | fifo_pop);
        rx_orphan_d = rx_orphan_q | (rx_started & empty);
        if (fifo_push) begin
            tag_mem_d[wr_ptr_q] = gnt_idx;
            wr_ptr_d            = ptr_inc(wr_ptr_q);
        end
        if (fifo_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({fifo_push, fifo_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        head_oh = '0;
        if (!empty) head_oh[head_idx] = 1'b1;
    end

    // With nothing outstanding head_oh is zero, so orphan strobes go nowhere.
    assign ch_rx_started    = {NUM_CH{rx_started}}    & head_oh;
    assign ch_rx_active     = {NUM_CH{rx_active}}     & head_oh;
    assign ch_rx_sbs_valid  = {NUM_CH{rx_sbs_valid}}  & head_oh;
    assign ch_rx_data_valid = {NUM_CH{rx_data_valid}} & head_oh;
    assign ch_rx_done       = {NUM_CH{rx_done}}       & head_oh;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_idx_q <= CH_W'(DEFAULT_CH);
            rr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            rx_orphan_q <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) tag_mem_q[i] <= '0;
        end else begin
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            rx_orphan_q <= rx_orphan_d;
            for (int i = 0; i < MAX_OUTSTANDING; i++) tag_mem_q[i] <= tag_mem_d[i];
        end
    end

endmodule

// File: tb/tb_mem_tx_arbiter.sv
// Two arbiters side by side on shared stimulus: A = 2 channels fixed priority,
// B = 4 channels round-robin with default channel 2. A queue-based model predicts
// every output each cycle; directed steps add literal expectations.
module tb_mem_tx_arbiter;
    localparam int MAXO = 3;

    typedef struct packed {
        logic       vld;
        logic [2:0] cmd;
        logic [1:0] dat;
        logic [3:0] gnt;
        logic [3:0] txs, txa, txn, txd;
        logic [3:0] rxs, rxa, rxb, rxv, rxd;
        logic       full, empty, orphan;
    } obs_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  cv, rsv, rw;
    logic [11:0] cmd_in;
    logic [7:0]  dat_in;
    logic tx_started, tx_active, tx_data_next, tx_done;
    logic rx_started, rx_active, rx_sbs_valid, rx_data_valid, rx_done;

    logic       a_vld, a_full, a_empty, a_orph;
    logic [2:0] a_cmd;
    logic [1:0] a_dat;
    logic [1:0] a_gnt, a_txs, a_txa, a_txn, a_txd, a_rxs, a_rxa, a_rxb, a_rxv, a_rxd;
    logic       b_vld, b_full, b_empty, b_orph;
    logic [2:0] b_cmd;
    logic [1:0] b_dat;
    logic [3:0] b_gnt, b_txs, b_txa, b_txn, b_txd, b_rxs, b_rxa, b_rxb, b_rxv, b_rxd;

    mem_tx_arbiter #(.NUM_CH(2), .IO_BITS(2), .CMD_BITS(3), .MAX_OUTSTANDING(MAXO),
                     .ARB_MODE(0), .DEFAULT_CH(0), .PAYLOAD_CYCLES(8)) dut_a (
        .clk(clk), .reset(reset),
        .ch_cmd_valid(cv[1:0]), .ch_reserve(rsv[1:0]), .ch_reply_wanted(rw[1:0]),
        .ch_cmd(cmd_in[5:0]), .ch_data(dat_in[3:0]),
        .tx_command_valid(a_vld), .tx_command(a_cmd), .tx_data(a_dat),
        .tx_command_started(tx_started), .tx_active(tx_active), .tx_data_next(tx_data_next), .tx_done(tx_done),
        .rx_started(rx_started), .rx_active(rx_active), .rx_sbs_valid(rx_sbs_valid),
        .rx_data_valid(rx_data_valid), .rx_done(rx_done),
        .grant(a_gnt), .ch_tx_started(a_txs), .ch_tx_active(a_txa), .ch_tx_data_next(a_txn), .ch_tx_done(a_txd),
        .ch_rx_started(a_rxs), .ch_rx_active(a_rxa), .ch_rx_sbs_valid(a_rxb),
        .ch_rx_data_valid(a_rxv), .ch_rx_done(a_rxd),
        .full(a_full), .empty(a_empty), .rx_orphan(a_orph));

    mem_tx_arbiter #(.NUM_CH(4), .IO_BITS(2), .CMD_BITS(3), .MAX_OUTSTANDING(MAXO),
                     .ARB_MODE(1), .DEFAULT_CH(2), .PAYLOAD_CYCLES(8)) dut_b (
        .clk(clk), .reset(reset),
        .ch_cmd_valid(cv), .ch_reserve(rsv), .ch_reply_wanted(rw),
        .ch_cmd(cmd_in), .ch_data(dat_in),
        .tx_command_valid(b_vld), .tx_command(b_cmd), .tx_data(b_dat),
        .tx_command_started(tx_started), .tx_active(tx_active), .tx_data_next(tx_data_next), .tx_done(tx_done),
        .rx_started(rx_started), .rx_active(rx_active), .rx_sbs_valid(rx_sbs_valid),
        .rx_data_valid(rx_data_valid), .rx_done(rx_done),
        .grant(b_gnt), .ch_tx_started(b_txs), .ch_tx_active(b_txa), .ch_tx_data_next(b_txn), .ch_tx_done(b_txd),
        .ch_rx_started(b_rxs), .ch_rx_active(b_rxa), .ch_rx_sbs_valid(b_rxb),
        .ch_rx_data_valid(b_rxv), .ch_rx_done(b_rxd),
        .full(b_full), .empty(b_empty), .rx_orphan(b_orph));

    obs_t act [2];
    always_comb begin
        act[0] = '{vld: a_vld, cmd: a_cmd, dat: a_dat, gnt: {2'b0, a_gnt},
                   txs: {2'b0, a_txs}, txa: {2'b0, a_txa}, txn: {2'b0, a_txn}, txd: {2'b0, a_txd},
                   rxs: {2'b0, a_rxs}, rxa: {2'b0, a_rxa}, rxb: {2'b0, a_rxb}, rxv: {2'b0, a_rxv},
                   rxd: {2'b0, a_rxd}, full: a_full, empty: a_empty, orphan: a_orph};
        act[1] = '{vld: b_vld, cmd: b_cmd, dat: b_dat, gnt: b_gnt,
                   txs: b_txs, txa: b_txa, txn: b_txn, txd: b_txd,
                   rxs: b_rxs, rxa: b_rxa, rxb: b_rxb, rxv: b_rxv,
                   rxd: b_rxd, full: b_full, empty: b_empty, orphan: b_orph};
    end

    // ---------------- behavioural model ----------------
    int nch [2] = '{2, 4};
    int md  [2] = '{0, 1};
    int dfl [2] = '{0, 2};
    int lg [2];
    int rr [2];
    int mcnt [2];
    int mq [2][MAXO];
    bit orph [2];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    function automatic void model_clear();
        for (int u = 0; u < 2; u++) begin
            lg[u] = dfl[u]; rr[u] = 0; mcnt[u] = 0; orph[u] = 1'b0;
            for (int k = 0; k < MAXO; k++) mq[u][k] = 0;
        end
    endfunction

    function automatic int model_arb(int u);
        logic [3:0] w;
        int c;
        w = (cv | rsv) & ((4'(1) << nch[u]) - 4'(1));
        if (w == 4'b0) return dfl[u];
        if (md[u] == 0) begin
            for (int i = nch[u] - 1; i >= 0; i--) if (w[i]) return i;
        end else begin
            for (int k = 0; k < nch[u]; k++) begin
                c = (rr[u] + k) % nch[u];
                if (w[c]) return c;
            end
        end
        return dfl[u];
    endfunction

    function automatic int model_g(int u);
        return tx_active ? lg[u] : model_arb(u);
    endfunction

    function automatic obs_t model_out(int u);
        obs_t o;
        int g;
        logic [3:0] hm;
        g     = model_g(u);
        o     = '0;
        o.vld = cv[g] & !(mcnt[u] == MAXO && rw[g]);
        o.cmd = cmd_in[g*3 +: 3];
        o.dat = dat_in[g*2 +: 2];
        o.gnt = 4'(1) << g;
        o.txs = 4'(tx_started) << g;
        o.txa = 4'(tx_active) << g;
        o.txn = 4'(tx_data_next) << g;
        o.txd = 4'(tx_done) << g;
        hm    = (mcnt[u] > 0) ? (4'(1) << mq[u][0]) : 4'b0;
        o.rxs = rx_started    ? hm : 4'b0;
        o.rxa = rx_active     ? hm : 4'b0;
        o.rxb = rx_sbs_valid  ? hm : 4'b0;
        o.rxv = rx_data_valid ? hm : 4'b0;
        o.rxd = rx_done       ? hm : 4'b0;
        o.full   = (mcnt[u] == MAXO);
        o.empty  = (mcnt[u] == 0);
        o.orphan = orph[u];
        return o;
    endfunction

    function automatic void model_step(int u);
        int g;
        bit pop, push;
        g    = model_g(u);
        pop  = rx_done && mcnt[u] > 0;
        push = tx_started && rw[g] && (mcnt[u] < MAXO || pop);
        if (rx_started && mcnt[u] == 0) orph[u] = 1'b1;
        if (md[u] == 1 && tx_done) rr[u] = (g + 1) % nch[u];
        if (!tx_active) lg[u] = g;
        if (pop) begin
            for (int k = 0; k < MAXO - 1; k++) mq[u][k] = mq[u][k+1];
            mcnt[u]--;
        end
        if (push) begin
            mq[u][mcnt[u]] = g;
            mcnt[u]++;
        end
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) model_clear();
        else for (int u = 0; u < 2; u++) model_step(u);
        if (clk) cyc++;
    end

    task automatic cmp(input int u, input string nm, input logic [3:0] a, input logic [3:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL cyc=%0d dut%0d %s got=%h want=%h", cyc, u, nm, a, e);
        end
    endtask

    obs_t exp_o;
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            exp_o = model_out(u);
            cmp(u, "vld",    4'(act[u].vld),    4'(exp_o.vld));
            cmp(u, "cmd",    4'(act[u].cmd),    4'(exp_o.cmd));
            cmp(u, "dat",    4'(act[u].dat),    4'(exp_o.dat));
            cmp(u, "grant",  act[u].gnt, exp_o.gnt);
            cmp(u, "ch_tx_started", act[u].txs, exp_o.txs);
            cmp(u, "ch_tx_active",  act[u].txa, exp_o.txa);
            cmp(u, "ch_tx_data_next", act[u].txn, exp_o.txn);
            cmp(u, "ch_tx_done",    act[u].txd, exp_o.txd);
            cmp(u, "ch_rx_started", act[u].rxs, exp_o.rxs);
            cmp(u, "ch_rx_active",  act[u].rxa, exp_o.rxa);
            cmp(u, "ch_rx_sbs_valid", act[u].rxb, exp_o.rxb);
            cmp(u, "ch_rx_data_valid", act[u].rxv, exp_o.rxv);
            cmp(u, "ch_rx_done",    act[u].rxd, exp_o.rxd);
            cmp(u, "full",   4'(act[u].full),   4'(exp_o.full));
            cmp(u, "empty",  4'(act[u].empty),  4'(exp_o.empty));
            cmp(u, "orphan", 4'(act[u].orphan), 4'(exp_o.orphan));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cv = '0; rsv = '0; rw = '0;
        cmd_in = {3'd7, 3'd5, 3'd6, 3'd1};
        dat_in = {2'd3, 2'd0, 2'd2, 2'd1};
        tx_started = 0; tx_active = 0; tx_data_next = 0; tx_done = 0;
        rx_started = 0; rx_active = 0; rx_sbs_valid = 0; rx_data_valid = 0; rx_done = 0;
    endtask

    int rd_ch [3] = '{0, 1, 0};
    int fill_ch [3] = '{0, 1, 1};
    int drain_ch [2] = '{1, 1};
    int act_left = 0;

    initial begin
        model_clear();
        idle();
        repeat (3) @(posedge clk);
        #1;
        cmp(0, "rst_grant",  4'(a_gnt),   4'b0001);
        cmp(0, "rst_empty",  4'(a_empty), 4'd1);
        cmp(0, "rst_full",   4'(a_full),  4'd0);
        cmp(0, "rst_orphan", 4'(a_orph),  4'd0);
        cmp(0, "rst_vld",    4'(a_vld),   4'd0);
        cmp(1, "rst_grant",  b_gnt,       4'b0100);
        reset = 1'b1;
        tick();

        // fixed priority: highest requester wins and keeps the grant mid-transfer
        cv = 4'b0011; #1;
        cmp(0, "fix_grant", 4'(a_gnt), 4'b0010);
        cmp(0, "fix_cmd",   4'(a_cmd), 4'd6);
        cmp(0, "fix_dat",   4'(a_dat), 4'd2);
        tick(); tx_active = 1; cv = 4'b0001; #1;
        cmp(0, "hold_grant", 4'(a_gnt), 4'b0010);
        cmp(0, "hold_vld",   4'(a_vld), 4'd0);
        tick(); tx_active = 0; #1;
        cmp(0, "release_grant", 4'(a_gnt), 4'b0001);
        tick(); idle();

        // three reads, full gating, in-order reply routing
        for (int k = 0; k < 3; k++) begin
            cv = 4'(1) << rd_ch[k]; rw = 4'b1111; tx_started = 1;
            tick();
        end
        idle(); #1;
        cmp(0, "full_after_3", 4'(a_full), 4'd1);
        cv = 4'b0001; rw = 4'b0001; #1;
        cmp(0, "full_read_blocked", 4'(a_vld), 4'd0);
        rw = 4'b0000; #1;
        cmp(0, "full_write_passes", 4'(a_vld), 4'd1);
        tick(); idle();
        for (int k = 0; k < 3; k++) begin
            rx_started = 1; tick();
            rx_started = 0; rx_done = 1; #1;
            cmp(0, "rx_order", 4'(a_rxd), 4'(1) << rd_ch[k]);
            tick(); rx_done = 0;
        end
        #1;
        cmp(0, "drained_empty", 4'(a_empty), 4'd1);

        // add+remove at full, then at count 1
        for (int k = 0; k < 3; k++) begin
            cv = 4'(1) << fill_ch[k]; rw = 4'b1111; tx_started = 1;
            tick();
        end
        idle();
        cv = 4'b0001; rw = 4'b0001; tx_started = 1; rx_done = 1; #1;
        cmp(0, "addrm_full_pop", 4'(a_rxd), 4'b0001);
        tick(); idle(); #1;
        cmp(0, "addrm_full_cnt", 4'(a_full), 4'd1);
        for (int k = 0; k < 2; k++) begin
            rx_done = 1; #1;
            cmp(0, "addrm_full_order", 4'(a_rxd), 4'(1) << drain_ch[k]);
            tick(); idle();
        end
        cv = 4'b0010; rw = 4'b0010; tx_started = 1; rx_done = 1; #1;
        cmp(0, "addrm_one_pop", 4'(a_rxd), 4'b0001);
        tick(); idle(); #1;
        cmp(0, "addrm_one_empty", 4'(a_empty), 4'd0);
        cmp(0, "addrm_one_full",  4'(a_full),  4'd0);
        rx_done = 1; #1;
        cmp(0, "addrm_one_head", 4'(a_rxd), 4'b0010);
        tick(); idle(); #1;
        cmp(0, "addrm_one_drained", 4'(a_empty), 4'd1);

        // round robin on B across five transfers
        cv = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            cmp(1, "rr_grant", b_gnt, 4'(1) << (k % 4));
            tick(); tx_active = 1; tx_done = 1;
            tick(); tx_active = 0; tx_done = 0;
        end
        idle();

        // reservation keeps the latched grant
        tick(); rsv = 4'b0001;
        tick(); tx_active = 1; cv = 4'b0010; #1;
        cmp(0, "rsv_hold",  4'(a_gnt), 4'b0001);
        cmp(0, "rsv_novld", 4'(a_vld), 4'd0);
        tick(); tx_active = 0; #1;
        cmp(0, "rsv_release", 4'(a_gnt), 4'b0010);
        tick(); idle();

        // orphan reply, then asynchronous reset mid-transfer
        rx_started = 1; #1;
        cmp(0, "orphan_drop", 4'(a_rxs), 4'd0);
        tick(); rx_started = 0; #1;
        cmp(0, "orphan_set", 4'(a_orph), 4'd1);
        cv = 4'b0010; rw = 4'b0010; tx_started = 1;
        tick(); tx_started = 0; tx_active = 1;
        tick(); #1;
        reset = 1'b0; #1;
        cmp(0, "arst_orphan", 4'(a_orph),  4'd0);
        cmp(0, "arst_empty",  4'(a_empty), 4'd1);
        cmp(0, "arst_grant",  4'(a_gnt),   4'b0001);
        cmp(1, "arst_grant",  b_gnt,       4'b0100);
        tick(); tick();
        reset = 1'b1; idle();
        tick();

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cv     = 4'($urandom);
            rsv    = 4'($urandom) & 4'($urandom);
            rw     = 4'($urandom);
            cmd_in = 12'($urandom);
            dat_in = 8'($urandom);
            if (act_left == 0) begin
                tx_active = ($urandom_range(0, 2) == 0);
                act_left  = $urandom_range(1, 4);
            end else begin
                act_left--;
            end
            tx_done       = tx_active && ($urandom_range(0, 3) == 0);
            tx_data_next  = 1'($urandom);
            rx_active     = 1'($urandom);
            rx_sbs_valid  = 1'($urandom);
            rx_data_valid = 1'($urandom);
            rx_started    = ($urandom_range(0, 5) == 0);
            rx_done       = ($urandom_range(0, 3) == 0);
            tx_started    = ($urandom_range(0, 2) == 0) &&
                            ((mcnt[0] < MAXO && mcnt[1] < MAXO) || rx_done);
            tick();
        end
        idle();
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_tx_arbiter.md
Name: mem_tx_arbiter

Overview:
- Arbitrates NUM_CH requesters onto the single memory_interface TX channel.
- Records, per outstanding read, which channel issued it, and routes RX strobes back to that channel in order.
- Successor to the fixed two-way prefetcher/scheduler muxing and 2-bit transaction FIFO in the CPU top level. Generalised in:
  - channel count;
  - arbitration mode (fixed or round-robin);
  - outstanding depth;
  - an orphan-reply error flag.

Parameters:
- NUM_CH, 2: number of requesting channels (>=2); channel index = tag.
- IO_BITS, 2: TX/RX data width per cycle.
- CMD_BITS, 3: TX command width (`TX_CMD_BITS).
- MAX_OUTSTANDING, 3: reply-tag FIFO depth (>=1).
- ARB_MODE, 0: 0 = fixed priority, highest index wins; 1 = round-robin.
- DEFAULT_CH, 0: channel granted when nobody requests.
- PAYLOAD_CYCLES, 8: passed through; sizes nothing here beyond documentation.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- ch_cmd_valid  in  NUM_CH  per-channel command request
- ch_reserve  in  NUM_CH  per-channel hold request: keeps the grant with no command
- ch_reply_wanted  in  NUM_CH  command expects an RX reply; a tag is queued
- ch_cmd  in  NUM_CH*CMD_BITS  flattened commands, channel i at [i*CMD_BITS +: CMD_BITS]
- ch_data  in  NUM_CH*IO_BITS  flattened TX payload
- tx_command_valid  out  1  to memory_interface
- tx_command  out  CMD_BITS  muxed command
- tx_data  out  IO_BITS  muxed payload
- tx_command_started, tx_active, tx_data_next, tx_done  in  1 each  from memory_interface
- rx_started, rx_active, rx_sbs_valid, rx_data_valid, rx_done  in  1 each  from memory_interface
- grant  out  NUM_CH  one-hot current TX owner
- ch_tx_started, ch_tx_active, ch_tx_data_next, ch_tx_done  out  NUM_CH each  TX strobes ANDed with grant
- ch_rx_started, ch_rx_active, ch_rx_sbs_valid, ch_rx_data_valid, ch_rx_done  out  NUM_CH each  RX strobes ANDed with the FIFO head owner
- full, empty  out  1 each  tag FIFO status
- rx_orphan  out  1  sticky error flag

Behaviour:
- Reset (reset=0, async):
  - grant latch = DEFAULT_CH; round-robin pointer = 0.
  - FIFO empty (empty=1, full=0); rx_orphan=0.
  - All outputs follow from this state: grant = one-hot DEFAULT_CH; tx_command_valid=0 unless a channel is requesting.
- Wanted vector: want[i] = ch_cmd_valid[i] | ch_reserve[i].
- Grant while !tx_active:
  - grant is combinational from want.
  - Mode 0: highest set index wins.
  - Mode 1: first set index at or after the RR pointer, cyclic.
  - No want: DEFAULT_CH.
  - A latch captures this grant every cycle that !tx_active.
- Grant while tx_active: grant = latched value. It cannot change mid-transfer.
- RR pointer (mode 1 only): on ch_tx_done of channel k, pointer <= (k+1) mod NUM_CH, wrapping at NUM_CH-1 -> 0.
- Reserve: a granted channel with reserve=1 and cmd_valid=0 keeps the grant (want=1). tx_command_valid stays 0.
- TX muxing:
  - tx_command and tx_data come from the granted channel.
  - tx_command_valid = ch_cmd_valid[g] & !(full & ch_reply_wanted[g]).
  - Non-reply commands bypass the full gate.
- Tag FIFO:
  - add = tx_command_started & ch_reply_wanted[g]; the pushed entry = g.
  - remove = rx_done.
  - Head = oldest entry. ch_rx_* is driven only to the head owner; all zero when empty.
  - Simultaneous add+remove: count unchanged, entries shift correctly. Works at full and at count=1.
  - full gating uses the registered count: a same-cycle remove does not unblock a new read. This is intentional and conservative.
- Orphan reply:
  - rx_started while empty sets rx_orphan (sticky until reset). The strobe is dropped.
  - rx_done while empty is ignored; the count does not underflow.
- Reset mid-transfer: all state clears immediately; outstanding tags are lost.
- Latency: TX path is zero-cycle combinational. The tag is visible at the head the cycle after add.

Test Plan:
- NUM_CH=2, mode 0, both ch_cmd_valid=1, !tx_active -> grant=2'b10. Ch1 cmd/data appear on tx_*. Dropping ch1 valid during tx_active leaves grant=2'b10 until tx_active=0.
- Three reads issued ch0, ch1, ch0 (reply_wanted=1), then three rx_done sequences -> ch_rx_done pulses on ch0, ch1, ch0 in order. full=1 after the third add; a fourth read has tx_command_valid=0, but a non-reply write on the same channel is issued.
- full with add+remove in the same cycle (count=3) -> count stays 3 and the new tag lands at the tail. With count=1, add+remove -> count 1, head = new tag.
- NUM_CH=4, mode 1, all want continuously -> grants cycle 0,1,2,3,0 across five tx_done events.
- ch0 reserve=1, ch1 cmd_valid=1, ch0 already latched and tx_active -> ch0 keeps the grant. After tx_active=0, mode 0 grants ch1.
- rx_started with FIFO empty -> rx_orphan=1 and no ch_rx_* strobe. Drop reset to 0 mid-transfer -> rx_orphan=0, empty=1, grant = DEFAULT_CH asynchronously.
